// File: rtl/dma_channel_arbiter_if.sv
// dma_channel_arbiter_if: channel descriptor handshake plus DMA engine command/status bundle
// Ports: ch_valid/ch_src/ch_dst/ch_len in, ch_ready/ch_done out (channel side);
// dma_start/dma_src_addr/dma_dst_addr/dma_len out, dma_done in (engine side).
// The slave modport is the arbiter; the master modport is the environment around it.
interface dma_channel_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH*ADDR_W-1:0] ch_src;
  logic [NUM_CH*ADDR_W-1:0] ch_dst;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic [NUM_CH-1:0]        ch_done;
  logic                     dma_start;
  logic [ADDR_W-1:0]        dma_src_addr;
  logic [ADDR_W-1:0]        dma_dst_addr;
  logic [LEN_W-1:0]         dma_len;
  logic                     dma_done;
  modport master (
    output ch_valid, ch_src, ch_dst, ch_len, dma_done,
    input  ch_ready, ch_done, dma_start, dma_src_addr, dma_dst_addr, dma_len
  );
  modport slave (
    input  ch_valid, ch_src, ch_dst, ch_len, dma_done,
    output ch_ready, ch_done, dma_start, dma_src_addr, dma_dst_addr, dma_len
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: round-robin sharing of one DMA copy engine among NUM_CH channels
// Ports: clk; rst_n async active-low; bus (slave) carries channel handshake/descriptors and
// engine start/addr/len/done; busy_o high in ISSUE/WAIT; grant_id_o current or last grant;
// xfer_count_o completed transfers, wrapping at 2^16.
module dma_channel_arbiter #(
  parameter int  NUM_CH = 4,
  parameter int  ADDR_W = 32,
  parameter int  LEN_W  = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dma_channel_arbiter_if.slave  bus,
  output logic                  busy_o,
  output logic [CH_W-1:0]       grant_id_o,
  output logic [15:0]           xfer_count_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state_q;
  logic [CH_W-1:0]   last_q, grant_q, win, idx;
  logic              start_q, busy_q;
  logic [NUM_CH-1:0] done_q;
  logic [15:0]       xfer_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q;
  logic              any_v;
  assign any_v = |bus.ch_valid;
  // Scan downward so the last hit is the nearest requester above last_q.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((32'(last_q) + 32'(i)) % NUM_CH);
      if (bus.ch_valid[idx]) win = idx;
    end
  end
  assign bus.ch_ready = (rst_n && state_q == IDLE) ? bus.ch_valid & (NUM_CH'(1) << win) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= CH_W'(NUM_CH - 1);
      grant_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      xfer_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        IDLE: if (any_v) begin
          src_q   <= bus.ch_src[win*ADDR_W +: ADDR_W];
          dst_q   <= bus.ch_dst[win*ADDR_W +: ADDR_W];
          len_q   <= bus.ch_len[win*LEN_W +: LEN_W];
          grant_q <= win;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: state_q <= WAIT;
        // The engine clears done on the start edge, so done seen here belongs to this transfer.
        WAIT: if (bus.dma_done) begin
          done_q  <= NUM_CH'(1) << grant_q;
          last_q  <= grant_q;
          xfer_q  <= xfer_q + 16'd1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ch_done      = done_q;
  assign bus.dma_start    = start_q;
  assign bus.dma_src_addr = src_q;
  assign bus.dma_dst_addr = dst_q;
  assign bus.dma_len      = len_q;
  assign busy_o           = busy_q;
  assign grant_id_o       = grant_q;
  assign xfer_count_o     = xfer_q;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb_dma_channel_arbiter: directed and randomized checks of the arbiter against an engine model and a transaction-level reference
module tb_dma_channel_arbiter;
  localparam int N = 4, AW = 32, LW = 8;
  typedef struct packed {logic [AW-1:0] src; logic [AW-1:0] dst; logic [LW-1:0] len;} desc_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [1:0] grant;
  logic [15:0] xfer;
  int n_checks = 0, n_fail = 0, cyc = 0;
  desc_t q [N][$];
  dma_channel_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .LEN_W(LW)) bus ();
  dma_channel_arbiter #(.NUM_CH(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .busy_o(busy), .grant_id_o(grant), .xfer_count_o(xfer)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  function automatic desc_t desc_of(input int c);
    desc_t d;
    d.src = bus.ch_src[c*AW +: AW];
    d.dst = bus.ch_dst[c*AW +: AW];
    d.len = bus.ch_len[c*LW +: LW];
    return d;
  endfunction
  // Engine: one word per cycle after the start edge, done latched until the next start.
  logic eng_done;
  logic [LW-1:0] eng_rem;
  int eng_words = 0;
  assign bus.dma_done = eng_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done <= 1'b0;
      eng_rem  <= '0;
    end else if (bus.dma_start) begin
      eng_done <= (bus.dma_len == '0);
      eng_rem  <= bus.dma_len;
    end else if (eng_rem != '0) begin
      eng_rem   <= eng_rem - 1'b1;
      eng_words <= eng_words + 1;
      eng_done  <= (eng_rem == 8'd1);
    end
  end
  // Reference: accept cycle, completion cycle and round-robin pointer as plain numbers.
  int m_acc, m_done_at, m_grant, m_done_ch, m_last;
  logic [15:0] m_count;
  desc_t m_desc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= -1; m_done_at <= -1; m_grant <= 0; m_done_ch <= 0; m_last <= N - 1;
      m_count <= '0; m_desc <= '0;
    end else if (m_acc < 0 && pick(bus.ch_valid, m_last) >= 0) begin
      m_acc   <= cyc;
      m_grant <= pick(bus.ch_valid, m_last);
      m_desc  <= desc_of(pick(bus.ch_valid, m_last));
    end else if (m_acc >= 0 && cyc >= m_acc + 2 && bus.dma_done) begin
      m_acc <= -1; m_last <= m_grant; m_count <= m_count + 16'd1;
      m_done_at <= cyc + 1; m_done_ch <= m_grant;
    end
  end
  // Requester protocol: valid and descriptor held until the ready cycle.
  logic [N-1:0] p_v, p_r;
  desc_t p_d [N];
  logic p_rst = 1'b0;
  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      assert (!(rst_n && p_rst && p_v[k] && !p_r[k]) || (bus.ch_valid[k] && desc_of(k) == p_d[k]))
        else $error("protocol violation on channel %0d", k);
    p_v <= bus.ch_valid;
    p_r <= bus.ch_ready;
    p_rst <= rst_n;
    for (int k = 0; k < N; k++) p_d[k] <= desc_of(k);
  end
  // Advance one cycle from a negedge: retire accepted requests, present queued ones.
  task automatic cycle();
    logic [N-1:0] acc;
    desc_t d;
    acc = bus.ch_valid & bus.ch_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) bus.ch_valid[k] = 1'b0;
      if (!bus.ch_valid[k] && q[k].size() > 0) begin
        d = q[k].pop_front();
        bus.ch_src[k*AW +: AW] = d.src;
        bus.ch_dst[k*AW +: AW] = d.dst;
        bus.ch_len[k*LW +: LW] = d.len;
        bus.ch_valid[k] = 1'b1;
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.ch_valid = '0;
    for (int k = 0; k < N; k++) q[k].delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic push(input int c, input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
    desc_t e;
    e.src = s; e.dst = d; e.len = l;
    q[c].push_back(e);
  endtask
  task automatic test_reset();
    bus.ch_valid = '1;
    #1;
    n_checks++;
    if (bus.ch_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", bus.ch_ready); end
    n_checks++;
    if ({bus.ch_done, bus.dma_start, busy, grant, xfer} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl got=%h exp=0", {bus.ch_done, bus.dma_start, busy, grant, xfer});
    end
    n_checks++;
    if ({bus.dma_src_addr, bus.dma_dst_addr, bus.dma_len} !== '0) begin
      n_fail++; $display("FAIL reset_dma got=%h exp=0", {bus.dma_src_addr, bus.dma_dst_addr, bus.dma_len});
    end
    @(negedge clk);
    n_checks++;
    if (bus.ch_ready !== '0) begin n_fail++; $display("FAIL reset_ready_clk got=%b exp=0000", bus.ch_ready); end
    bus.ch_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.ch_ready, busy, bus.dma_start} !== '0) begin
      n_fail++; $display("FAIL idle_after_reset got=%b exp=0", {bus.ch_ready, busy, bus.dma_start});
    end
  endtask
  task automatic test_single();
    int t_acc = -1, t_start = -1, t_done = -1, n_done = 0, unstable = 0, w0;
    logic [N-1:0] dval = '0;
    do_reset();
    w0 = eng_words;
    push(1, 32'h1000, 32'h2000, 8'd4);
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (bus.ch_ready == 4'b0010 && t_acc < 0) t_acc = cyc;
      if (bus.dma_start) t_start = cyc;
      if (t_acc >= 0 && cyc > t_acc && n_done == 0 &&
          {bus.dma_src_addr, bus.dma_dst_addr, bus.dma_len} !== {32'h1000, 32'h2000, 8'd4}) unstable++;
      if (bus.ch_done != '0) begin n_done++; t_done = cyc; dval = bus.ch_done; end
    end
    n_checks++;
    if (t_acc < 0) begin n_fail++; $display("FAIL single_accept timeout, ch_ready[1] never seen"); end
    n_checks++;
    if (t_start != t_acc + 1) begin n_fail++; $display("FAIL single_start got=%0d exp=%0d", t_start, t_acc + 1); end
    n_checks++;
    if (unstable != 0) begin n_fail++; $display("FAIL single_stable got=%0d unstable cycles exp=0", unstable); end
    n_checks++;
    if (n_done != 1 || dval !== 4'b0010) begin n_fail++; $display("FAIL single_done got=%0d pulses val=%b exp=1 pulse 0010", n_done, dval); end
    n_checks++;
    if (t_done != t_acc + 7) begin n_fail++; $display("FAIL single_done_time got=%0d exp=%0d", t_done, t_acc + 7); end
    n_checks++;
    if (xfer !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_count got=%0d busy=%b exp=1 busy=0", xfer, busy); end
    n_checks++;
    if (eng_words - w0 != 4) begin n_fail++; $display("FAIL single_words got=%0d exp=4", eng_words - w0); end
  endtask
  task automatic test_fairness();
    int order[$];
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < N; k++) push(k, 32'(k*256 + j), 32'(k*256 + j + 16), 8'd1);
    for (int i = 0; i < 80 && xfer != 16'd8; i++) begin
      cycle();
      for (int k = 0; k < N; k++) if (bus.ch_ready[k]) order.push_back(k);
    end
    n_checks++;
    if (order.size() != 8 || xfer !== 16'd8) begin n_fail++; $display("FAIL fair_count got=%0d grants %0d done exp=8", order.size(), xfer); end
    for (int i = 0; i < order.size() && i < 8; i++) begin
      n_checks++;
      if (order[i] != i % N) begin n_fail++; $display("FAIL fair_order idx=%0d got=%0d exp=%0d", i, order[i], i % N); end
    end
  endtask
  task automatic test_zero_len();
    int t_acc = -1, t_start = -1, t_done = -1, w0;
    logic [N-1:0] dval = '0;
    do_reset();
    w0 = eng_words;
    push(2, 32'h3000, 32'h4000, 8'd0);
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (bus.ch_ready == 4'b0100 && t_acc < 0) t_acc = cyc;
      if (bus.dma_start) t_start = cyc;
      if (bus.ch_done != '0) begin t_done = cyc; dval = bus.ch_done; end
    end
    n_checks++;
    if (t_acc < 0 || t_start != t_acc + 1) begin n_fail++; $display("FAIL zero_start got=%0d exp=%0d", t_start, t_acc + 1); end
    n_checks++;
    if (t_done != t_acc + 3 || dval !== 4'b0100) begin n_fail++; $display("FAIL zero_done got=%0d val=%b exp=%0d val=0100", t_done, dval, t_acc + 3); end
    n_checks++;
    if (eng_words != w0) begin n_fail++; $display("FAIL zero_traffic got=%0d words exp=0", eng_words - w0); end
  endtask
  task automatic test_priority_wrap();
    int order[$];
    do_reset();
    push(3, 32'h50, 32'h60, 8'd2);
    for (int i = 0; i < 30 && xfer != 16'd1; i++) cycle();
    n_checks++;
    if (grant !== 2'd3 || xfer !== 16'd1) begin n_fail++; $display("FAIL wrap_first got grant=%0d count=%0d exp grant=3 count=1", grant, xfer); end
    push(0, 32'h70, 32'h80, 8'd1);
    push(2, 32'h90, 32'ha0, 8'd1);
    for (int i = 0; i < 40 && order.size() < 2; i++) begin
      cycle();
      for (int k = 0; k < N; k++) if (bus.ch_ready[k]) order.push_back(k);
    end
    n_checks++;
    if (order.size() != 2) begin n_fail++; $display("FAIL wrap_grants got=%0d exp=2", order.size()); end
    else begin
      n_checks++;
      if (order[0] != 0 || order[1] != 2) begin n_fail++; $display("FAIL wrap_order got=%0d,%0d exp=0,2", order[0], order[1]); end
    end
  endtask
  task automatic test_reset_mid();
    bit seen = 0;
    int dn = 0, first = -1;
    do_reset();
    push(1, 32'hbeef0000, 32'hcafe0000, 8'd8);
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (busy && !bus.dma_start) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL mid_wait timeout, busy=%b", busy); end
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ch_ready !== '0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0000", bus.ch_ready); end
    n_checks++;
    if ({bus.ch_done, bus.dma_start, busy, grant, xfer, bus.dma_src_addr, bus.dma_dst_addr, bus.dma_len} !== '0) begin
      n_fail++; $display("FAIL mid_outputs got busy=%b grant=%0d src=%h len=%0d exp=0", busy, grant, bus.dma_src_addr, bus.dma_len);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.ch_done != '0) dn++;
    end
    rst_n = 1'b1;
    push(3, 32'h11, 32'h22, 8'd1);
    push(0, 32'h33, 32'h44, 8'd1);
    for (int i = 0; i < 20 && first < 0; i++) begin
      cycle();
      if (bus.ch_done != '0) dn++;
      for (int k = N - 1; k >= 0; k--) if (bus.ch_ready[k]) first = k;
    end
    n_checks++;
    if (dn != 0) begin n_fail++; $display("FAIL mid_no_done got=%0d pulses exp=0", dn); end
    n_checks++;
    if (first != 0) begin n_fail++; $display("FAIL mid_first_grant got=%0d exp=0", first); end
  endtask
  task automatic test_late_request();
    bit seen = 0, got = 0;
    int early = 0;
    logic [N-1:0] dval = '0, rval = '0;
    do_reset();
    push(0, 32'h100, 32'h200, 8'd3);
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (busy && !bus.dma_start) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL late_wait timeout, busy=%b", busy); end
    push(3, 32'h300, 32'h400, 8'd2);
    for (int i = 0; i < 30 && !got; i++) begin
      cycle();
      if (bus.ch_done != '0) begin got = 1; dval = bus.ch_done; rval = bus.ch_ready; end
      else if (bus.ch_ready[3]) early++;
    end
    n_checks++;
    if (early != 0) begin n_fail++; $display("FAIL late_hold got=%0d early ready cycles exp=0", early); end
    n_checks++;
    if (!got || dval !== 4'b0001) begin n_fail++; $display("FAIL late_done got=%b exp=0001", dval); end
    n_checks++;
    if (rval !== 4'b1000) begin n_fail++; $display("FAIL late_accept got=%b exp=1000", rval); end
    for (int i = 0; i < 30 && xfer != 16'd2; i++) cycle();
    n_checks++;
    if (xfer !== 16'd2) begin n_fail++; $display("FAIL late_count got=%0d exp=2", xfer); end
  endtask
  task automatic test_random();
    int pushed = 0, c, p;
    desc_t d;
    logic [N-1:0] er, ed;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i < 250 && pushed < 40 && $urandom_range(0, 2) == 0) begin
        c = int'($urandom_range(0, N - 1));
        if (q[c].size() < 2) begin
          d.src = $urandom; d.dst = $urandom; d.len = LW'($urandom_range(0, 5));
          q[c].push_back(d);
          pushed++;
        end
      end
      cycle();
      p = pick(bus.ch_valid, m_last);
      er = (m_acc < 0 && p >= 0) ? N'(1) << p : '0;
      ed = (cyc == m_done_at) ? N'(1) << m_done_ch : '0;
      n_checks++;
      if ({bus.ch_ready, bus.ch_done} !== {er, ed}) begin
        n_fail++; $display("FAIL rand_hs cyc=%0d got ready=%b done=%b exp ready=%b done=%b", cyc, bus.ch_ready, bus.ch_done, er, ed);
      end
      n_checks++;
      if ({bus.dma_start, busy, grant, xfer} !== {m_acc >= 0 && cyc == m_acc + 1, m_acc >= 0 && cyc > m_acc, 2'(m_grant), m_count}) begin
        n_fail++; $display("FAIL rand_ctrl cyc=%0d got start=%b busy=%b grant=%0d count=%0d exp grant=%0d count=%0d",
                           cyc, bus.dma_start, busy, grant, xfer, m_grant, m_count);
      end
      n_checks++;
      if ({bus.dma_src_addr, bus.dma_dst_addr, bus.dma_len} !== m_desc) begin
        n_fail++; $display("FAIL rand_dma cyc=%0d got=%h exp=%h", cyc, {bus.dma_src_addr, bus.dma_dst_addr, bus.dma_len}, m_desc);
      end
    end
    n_checks++;
    if (xfer !== 16'(pushed)) begin n_fail++; $display("FAIL rand_total got=%0d exp=%0d", xfer, pushed); end
  endtask
  initial begin
    bus.ch_valid = '0;
    bus.ch_src = '0;
    bus.ch_dst = '0;
    bus.ch_len = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_zero_len();
    test_priority_wrap();
    test_reset_mid();
    test_late_request();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
